// File: rtl/key_seq_pkg.sv
// Shared types for the sequential code lock.
// Symbol width, symbol type and lock FSM states.
package key_seq_pkg;

   localparam int SYM_W = 2;

   typedef logic [SYM_W-1:0] sym_t;

   typedef enum logic [1:0] {
      IDLE,
      ENTER,
      UNLOCK,
      LOCKOUT
   } state_t;

endpackage

// File: rtl/key_seq_lock_sym_eq.sv
// Combinational symbol equality comparator.
// Compares the incoming symbol with the expected key symbol.
import key_seq_pkg::*;

module sym_eq (
   input  sym_t a,
   input  sym_t b,
   output logic eq
);

   assign eq = (a == b);

endmodule

// File: rtl/key_seq_lock.sv
// Sequential code lock checking 2-bit symbols against a programmable key.
// Define KEY_SEQ_LOCKOUT_EN to build the failed-entry lockout timer.
import key_seq_pkg::*;

module key_seq_lock #(
   parameter int N_SYM       = 4,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  sym_t                     sym_in,
   input  logic                     sym_valid,
   input  logic                     prog,
   input  logic                     clear,
   output logic                     ready,
   output logic                     unlocked,
   output logic                     fail,
   output logic [$clog2(N_SYM)-1:0] pos,
   output logic                     locked_out
);

   localparam int PW = $clog2(N_SYM);
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam logic [PW-1:0] LAST = PW'(N_SYM - 1);

   if (N_SYM < 2 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_cfg_err
      $error("key_seq_lock: illegal parameter set");
   end

   state_t          state_q;
   sym_t            key_q [N_SYM];
   logic [PW-1:0]   pos_q;
   logic [PW-1:0]   wr_idx_q;
   logic            mis_q;
   logic [FW-1:0]   fail_cnt_q;
   logic            unlocked_q;
   logic            fail_q;
   logic            sym_ok;
   logic            mis_d;
   logic [PW-1:0]   wr_idx_d;

   sym_eq u_eq (
      .a  (sym_in),
      .b  (key_q[pos_q]),
      .eq (sym_ok)
   );

   assign mis_d    = mis_q | ~sym_ok;
   assign wr_idx_d = (wr_idx_q == LAST) ? '0 : wr_idx_q + 1'b1;

`ifdef KEY_SEQ_LOCKOUT_EN
   localparam int CW = $clog2(LOCK_CYCLES + 1);
   logic [CW-1:0] cnt_q;
   logic          ready_q;
   logic          locked_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         for (int i = 0; i < N_SYM; i++) key_q[i] <= '0;
         pos_q      <= '0;
         wr_idx_q   <= '0;
         mis_q      <= 1'b0;
         fail_cnt_q <= '0;
         unlocked_q <= 1'b0;
         fail_q     <= 1'b0;
`ifdef KEY_SEQ_LOCKOUT_EN
         cnt_q      <= '0;
         ready_q    <= 1'b1;
         locked_q   <= 1'b0;
`endif
      end else begin
         fail_q <= 1'b0;
`ifdef KEY_SEQ_LOCKOUT_EN
         if (state_q == LOCKOUT) begin
            if (cnt_q == '0) begin
               state_q    <= IDLE;
               fail_cnt_q <= '0;
               ready_q    <= 1'b1;
               locked_q   <= 1'b0;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end else
`endif
         if (clear) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            mis_q      <= 1'b0;
            unlocked_q <= 1'b0;
         end else if (prog && sym_valid) begin
            key_q[wr_idx_q] <= sym_in;
            wr_idx_q   <= wr_idx_d;
            state_q    <= IDLE;
            pos_q      <= '0;
            mis_q      <= 1'b0;
            unlocked_q <= 1'b0;
         end else if (!prog && sym_valid &&
                      (state_q == IDLE || state_q == ENTER)) begin
            if (pos_q != LAST) begin
               pos_q   <= pos_q + 1'b1;
               mis_q   <= mis_d;
               state_q <= ENTER;
            end else begin
               pos_q <= '0;
               mis_q <= 1'b0;
               if (!mis_d) begin
                  state_q    <= UNLOCK;
                  unlocked_q <= 1'b1;
                  fail_cnt_q <= '0;
               end else begin
                  state_q <= IDLE;
                  fail_q  <= 1'b1;
                  if (fail_cnt_q != FW'(MAX_FAIL))
                     fail_cnt_q <= fail_cnt_q + 1'b1;
`ifdef KEY_SEQ_LOCKOUT_EN
                  // Third strike goes straight to the timed lockout
                  if (int'(fail_cnt_q) + 1 >= MAX_FAIL) begin
                     state_q  <= LOCKOUT;
                     cnt_q    <= CW'(LOCK_CYCLES - 1);
                     ready_q  <= 1'b0;
                     locked_q <= 1'b1;
                  end
`endif
               end
            end
         end
      end
   end

   assign unlocked = unlocked_q;
   assign fail     = fail_q;
   assign pos      = pos_q;

`ifdef KEY_SEQ_LOCKOUT_EN
   assign ready      = ready_q;
   assign locked_out = locked_q;
`else
   assign ready      = 1'b1;
   assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_key_seq_lock.sv
// Randomized scoreboard bench for key_seq_lock against a queue-based model.
// Honours KEY_SEQ_LOCKOUT_EN the same way as the design.
import key_seq_pkg::*;

module tb_key_seq_lock;

   localparam int N_SYM       = 4;
   localparam int MAX_FAIL    = 3;
   localparam int LOCK_CYCLES = 16;
`ifdef KEY_SEQ_LOCKOUT_EN
   localparam bit LOCKOUT_BUILD = 1'b1;
`else
   localparam bit LOCKOUT_BUILD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   sym_t       sym_in = '0;
   logic       sym_valid = 1'b0;
   logic       prog = 1'b0;
   logic       clear = 1'b0;
   logic       ready;
   logic       unlocked;
   logic       fail;
   logic [1:0] pos;
   logic       locked_out;

   key_seq_lock #(
      .N_SYM       (N_SYM),
      .MAX_FAIL    (MAX_FAIL),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sym_in     (sym_in),
      .sym_valid  (sym_valid),
      .prog       (prog),
      .clear      (clear),
      .ready      (ready),
      .unlocked   (unlocked),
      .fail       (fail),
      .pos        (pos),
      .locked_out (locked_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ready;
      logic       unlocked;
      logic       fail;
      logic       locked_out;
      logic [1:0] pos;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   // Reference model: key array, list of symbols entered so far, flags
   sym_t m_key [N_SYM];
   int   m_wr = 0;
   sym_t m_ent[$];
   bit   m_unl = 0;
   int   m_fails = 0;
   int   m_lock = 0;
   bit   m_fail = 0;

   function automatic bit entry_matches();
      for (int i = 0; i < N_SYM; i++)
         if (m_ent[i] != m_key[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_step(bit r, sym_t s, bit v, bit p, bit c);
      exp_t e;
      m_fail = 1'b0;
      if (r) begin
         for (int i = 0; i < N_SYM; i++) m_key[i] = '0;
         m_wr = 0; m_ent = {}; m_unl = 0; m_fails = 0; m_lock = 0;
      end else if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_fails = 0;
      end else if (c) begin
         m_ent = {}; m_unl = 0;
      end else if (p && v) begin
         m_key[m_wr] = s;
         m_wr = (m_wr + 1) % N_SYM;
         m_ent = {}; m_unl = 0;
      end else if (v && !p && !m_unl) begin
         m_ent.push_back(s);
         if (m_ent.size() == N_SYM) begin
            if (entry_matches()) begin
               m_unl = 1; m_fails = 0;
            end else begin
               m_fail = 1; m_fails++;
               if (LOCKOUT_BUILD && m_fails >= MAX_FAIL) m_lock = LOCK_CYCLES;
            end
            m_ent = {};
         end
      end
      e.ready      = (m_lock == 0);
      e.unlocked   = m_unl;
      e.fail       = m_fail;
      e.locked_out = (m_lock > 0);
      e.pos        = 2'(m_ent.size());
      exp_q.push_back(e);
   endfunction

   task automatic step(bit r, sym_t s, bit v, bit p, bit c);
      @(negedge clk);
      reset = r; sym_in = s; sym_valid = v; prog = p; clear = c;
      model_step(r, s, v, p, c);
   endtask

   task automatic seq4(bit p, sym_t a, sym_t b, sym_t c, sym_t d);
      step(0, a, 1, p, 0);
      step(0, b, 1, p, 0);
      step(0, c, 1, p, 0);
      step(0, d, 1, p, 0);
   endtask

   initial begin : monitor
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{ready, unlocked, fail, locked_out, pos};
            checks++;
            if (a === e) passed++;
            else
               $display("FAIL outputs t=%0t got rdy=%b unl=%b fail=%b lo=%b pos=%0d want rdy=%b unl=%b fail=%b lo=%b pos=%0d",
                        $time, a.ready, a.unlocked, a.fail, a.locked_out, a.pos,
                        e.ready, e.unlocked, e.fail, e.locked_out, e.pos);
         end
      end
   end

   initial begin : driver
      int   guard;
      sym_t s;
      bit   r, v, p, c;
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // Program and correct entry
      seq4(1, 2, 1, 3, 0);
      seq4(0, 2, 1, 3, 0);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      // Wrong entry, no early reject
      seq4(0, 2, 0, 3, 0);
      step(0, 0, 0, 0, 0);
      // Partial entry then clear
      step(0, 2, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      seq4(0, 2, 1, 3, 0);
      step(0, 0, 0, 0, 1);
      // Three strikes, then hammer on inputs during lockout
      repeat (3) seq4(0, 3, 3, 3, 3);
      for (int i = 0; i < LOCK_CYCLES + 2; i++)
         step(0, sym_t'($urandom), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      step(0, 0, 0, 0, 1);
      seq4(0, m_key[0], m_key[1], m_key[2], m_key[3]);
      // Reset mid-entry and during unlock
      step(0, 0, 0, 0, 1);
      step(0, m_key[0], 1, 0, 0);
      step(0, m_key[1], 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      seq4(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      seq4(0, 0, 0, 0, 0);
      // Programming during entry aborts it; wr_idx wraps
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0);
      seq4(1, 1, 2, 3, 1);
      step(0, 2, 1, 1, 0);
      seq4(0, 2, 2, 3, 1);
      // Randomized traffic biased towards correct symbols
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         c = ($urandom_range(0, 39) == 0);
         p = ($urandom_range(0, 11) == 0);
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 8) s = m_key[m_ent.size()];
         else s = sym_t'($urandom);
         step(r, s, v, p, c);
      end
      step(0, 0, 0, 0, 0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
